cp0_intr_ctrl: RTL and testbench
================================

Name: cp0_intr_ctrl

Overview:
- Parametrised coprocessor-0 interrupt unit for the 5-stage pipelined MIPS CPU.
- Generalises the single-source jump_en/jump_addr interrupt path to NUM_IRQ prioritised, maskable channels, each configurable as edge or level.
- Supports vectored entry, EPC capture and ERET return.
- Sits beside the datapath on its cp_addr_r/cp_data_r/cp_data_w/ret_addr/jump_en/jump_addr interface; it is the CP0 register file for mfc0/mtc0.

Parameters:
- NUM_IRQ, 4, number of interrupt channels (1..8); channel 0 has highest priority.
- IRQ_EDGE, 8'h00, per-channel mode bit: 1 = rising-edge, 0 = level.
- VEC_SHIFT, 3, vector spacing: handler address = EBASE + (idx << VEC_SHIFT).
- EBASE_RST, 32'h0000_0100, reset value of EBASE.
- STACK_DEPTH, 4, EPC/IE save depth; used only with CP0_NESTED_EN.

Ports:
- clk  in  1  main clock
- rst_n  in  1  asynchronous active-low reset
- irq_in  in  NUM_IRQ  asynchronous interrupt requests
- cp_addr_r  in  5  CP0 read address (mfc0 rd)
- cp_data_r  out  32  CP0 read data, combinational
- cp_addr_w  in  5  CP0 write address (mtc0 rd)
- cp_data_w  in  32  CP0 write data
- cp_wen  in  1  mtc0 write strobe
- eret  in  1  ERET decoded in ID, one-cycle pulse
- ret_addr  in  32  PC to save into EPC on entry
- take_ok  in  1  pipeline may be redirected this cycle (ID valid, no stall)
- jump_en  out  1  one-cycle redirect pulse
- jump_addr  out  32  redirect target
- int_ack  out  NUM_IRQ  one-hot pulse when a channel is taken
- in_isr  out  1  a handler is active

Behaviour:
- Registers: 12 STATUS (bit0 IE, bits[8+NUM_IRQ-1:8] MASK), 13 CAUSE (bits[8+NUM_IRQ-1:8] PEND, read-only; bits[6:2] EXCCODE = 0 for interrupt; bits[28:26] = taken index), 14 EPC, 15 EBASE. Any other address reads 0; writes to it are ignored.
- Reset values: STATUS = 0, CAUSE = 0, EPC = 0, EBASE = EBASE_RST. Outputs jump_en = 0, jump_addr = 0, int_ack = 0, in_isr = 0. FSM = IDLE. Synchronisers and edge registers are cleared.
- Input path: each irq_in goes through a 2-FF synchroniser.
  - Edge channel: a pending flop is set on a 0->1 of the synchronised signal. It is cleared by int_ack for that channel, or by writing 1 to the matching CAUSE PEND bit (W1C).
  - Level channel: PEND mirrors the synchronised level. W1C has no effect.
- Eligible = PEND & MASK. Winner = lowest-index eligible bit.
- FSM:
  - IDLE -> TAKE when IE=1, eligible != 0 and take_ok=1.
  - TAKE (1 cycle): jump_en=1; jump_addr = EBASE + (winner << VEC_SHIFT); EPC <= ret_addr; IE <= 0; CAUSE index <= winner; int_ack[winner]=1. Next state ISR.
  - ISR: in_isr=1. On eret, go to RET.
  - RET (1 cycle): jump_en=1; jump_addr=EPC; IE <= 1. Next state IDLE.
- Latency: irq_in rise to jump_en is 3 cycles minimum (2 sync + 1 registered decision), longer while take_ok=0.
- Simultaneous events:
  - Interrupt becomes eligible while an eret arrives in ISR: eret wins; the interrupt is taken no earlier than 1 cycle after RET.
  - mtc0 in the same cycle as TAKE: the TAKE updates to EPC and IE override the write; other fields take the written value.
  - eret while in IDLE: ignored.
  - mtc0 takes effect on the next cycle.
- Width rule: vector arithmetic is 32-bit and wraps modulo 2^32.
- rst_n low mid-handler: immediate return to reset state; any pending jump_en pulse is dropped.

Optional Feature:
- Macro: CP0_NESTED_EN.
- Defined:
  - In ISR, an eligible channel with index strictly lower than the active one preempts when take_ok=1. This passes through TAKE and pushes {EPC, IE, index} onto a STACK_DEPTH-entry stack.
  - RET pops the stack and restores EPC, index and IE; in_isr stays 1 until the stack is empty.
  - When the stack is full, preemption is blocked.
- Undefined: no stack exists; IE=0 blocks all entry while in ISR.

Test Plan:
- Reset, then read regs 12/13/14/15 -> 0, 0, 0, 32'h100; jump_en=0.
- STATUS=32'h0000_0F01, irq_in[2] pulses high, take_ok=1, ret_addr=32'h40 -> jump_en on cycle 3, jump_addr=32'h110, EPC=32'h40, int_ack=4'b0100, IE=0.
- irq_in[1] and irq_in[3] rise together -> channel 1 taken, jump_addr=32'h108; after eret, jump_addr=32'h40 and channel 3 follows.
- MASK bit 0 cleared, irq_in[0] high -> no jump_en; CAUSE PEND bit 8 reads 1. Edge channel: W1C 32'h100 to CAUSE -> PEND clears.
- take_ok held 0 for 5 cycles with an eligible IRQ -> jump_en asserts in the first cycle after take_ok rises.
- CP0_NESTED_EN: in ISR of channel 3, channel 0 rises -> preempted to 32'h100; two erets return to channel-3 EPC, then to the original EPC; in_isr falls after the second.

Source files
------------

// File: rtl/cp0_intr_ctrl.sv
// CP0 interrupt unit: prioritised maskable IRQ channels, vectored entry, EPC/ERET.
// Optional nested preemption with an EPC/IE/index stack when CP0_NESTED_EN is defined.
module cp0_intr_ctrl #(
    parameter int          NUM_IRQ     = 4,
    parameter logic [7:0]  IRQ_EDGE    = 8'h00,
    parameter int          VEC_SHIFT   = 3,
    parameter logic [31:0] EBASE_RST   = 32'h0000_0100,
    parameter int          STACK_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [4:0]         cp_addr_r,
    output logic [31:0]        cp_data_r,
    input  logic [4:0]         cp_addr_w,
    input  logic [31:0]        cp_data_w,
    input  logic               cp_wen,
    input  logic               eret,
    input  logic [31:0]        ret_addr,
    input  logic               take_ok,
    output logic               jump_en,
    output logic [31:0]        jump_addr,
    output logic [NUM_IRQ-1:0] int_ack,
    output logic               in_isr
);
    typedef enum logic [1:0] {S_IDLE, S_TAKE, S_ISR, S_RET} state_t;

    if (NUM_IRQ < 1 || NUM_IRQ > 8 || STACK_DEPTH < 1) begin : g_bad_param
        $error("cp0_intr_ctrl: NUM_IRQ must be 1..8 and STACK_DEPTH >= 1");
    end

    state_t             state;
    logic [NUM_IRQ-1:0] irq_s1, irq_s2, irq_d, pend_q;
    logic [NUM_IRQ-1:0] rise, pend, eligible, mask, w1c, win_oh;
    logic               ie, have_win, take_idle, take_pre, take;
    logic [2:0]         cause_idx, win;
    logic [31:0]        epc, ebase, vec_addr;

    // Edge-channel PEND includes the rise seen this cycle so both modes keep 3-cycle latency.
    always_comb begin
        rise     = irq_s2 & ~irq_d;
        have_win = 1'b0;
        win      = 3'd0;
        for (int i = 0; i < NUM_IRQ; i++)
            pend[i] = IRQ_EDGE[i] ? (pend_q[i] | rise[i]) : irq_s2[i];
        eligible = pend & mask;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                have_win = 1'b1;
                win      = 3'(i);
            end
        end
        win_oh   = NUM_IRQ'(1) << win;
        vec_addr = ebase + (32'(win) << VEC_SHIFT);
        w1c      = (cp_wen && cp_addr_w == 5'd13) ? cp_data_w[8 +: NUM_IRQ] : '0;
    end

    assign take_idle = (state == S_IDLE) && ie && have_win && take_ok;
    assign take      = take_idle || take_pre;

`ifdef CP0_NESTED_EN
    localparam int SP_W = $clog2(STACK_DEPTH + 1);
    logic [SP_W-1:0] sp;
    logic [31:0]     stk_epc [STACK_DEPTH];
    logic            stk_ie  [STACK_DEPTH];
    logic [2:0]      stk_idx [STACK_DEPTH];

    assign take_pre = (state == S_ISR) && !eret && have_win && (win < cause_idx)
                      && take_ok && (sp < SP_W'(STACK_DEPTH));
`else
    assign take_pre = 1'b0;
`endif

    always_comb begin
        cp_data_r = '0;
        case (cp_addr_r)
            5'd12: begin
                cp_data_r[0]            = ie;
                cp_data_r[8 +: NUM_IRQ] = mask;
            end
            5'd13: begin
                cp_data_r[8 +: NUM_IRQ] = pend;
                cp_data_r[28:26]        = cause_idx;
            end
            5'd14:   cp_data_r = epc;
            5'd15:   cp_data_r = ebase;
            default: cp_data_r = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_s1 <= '0;
            irq_s2 <= '0;
            irq_d  <= '0;
            pend_q <= '0;
        end else begin
            irq_s1 <= irq_in;
            irq_s2 <= irq_s1;
            irq_d  <= irq_s2;
            for (int i = 0; i < NUM_IRQ; i++)
                pend_q[i] <= IRQ_EDGE[i] &&
                             ((pend_q[i] | rise[i]) & ~(take & win_oh[i]) & ~w1c[i]);
        end
    end

    // Register writes come first so TAKE/RET updates to EPC and IE override a same-cycle mtc0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ie        <= 1'b0;
            mask      <= '0;
            cause_idx <= 3'd0;
            epc       <= '0;
            ebase     <= EBASE_RST;
            jump_en   <= 1'b0;
            jump_addr <= '0;
            int_ack   <= '0;
            in_isr    <= 1'b0;
`ifdef CP0_NESTED_EN
            sp        <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stk_epc[i] <= '0;
                stk_ie[i]  <= 1'b0;
                stk_idx[i] <= 3'd0;
            end
`endif
        end else begin
            jump_en <= 1'b0;
            int_ack <= '0;
            if (cp_wen) begin
                case (cp_addr_w)
                    5'd12: begin
                        ie   <= cp_data_w[0];
                        mask <= cp_data_w[8 +: NUM_IRQ];
                    end
                    5'd14:   epc   <= cp_data_w;
                    5'd15:   ebase <= cp_data_w;
                    default: ;
                endcase
            end
            case (state)
                S_IDLE: ;
                S_TAKE: begin
                    state  <= S_ISR;
                    in_isr <= 1'b1;
                end
                S_ISR: begin
                    if (eret) begin
                        state     <= S_RET;
                        jump_en   <= 1'b1;
                        jump_addr <= epc;
`ifdef CP0_NESTED_EN
                        if (sp != '0) begin
                            epc       <= stk_epc[sp - 1'b1];
                            ie        <= stk_ie[sp - 1'b1];
                            cause_idx <= stk_idx[sp - 1'b1];
                            sp        <= sp - 1'b1;
                            in_isr    <= 1'b1;
                        end else begin
                            ie     <= 1'b1;
                            in_isr <= 1'b0;
                        end
`else
                        ie     <= 1'b1;
                        in_isr <= 1'b0;
`endif
                    end
                end
                S_RET:   state <= in_isr ? S_ISR : S_IDLE;
                default: state <= S_IDLE;
            endcase
            if (take) begin
`ifdef CP0_NESTED_EN
                if (state == S_ISR) begin
                    stk_epc[sp] <= epc;
                    stk_ie[sp]  <= ie;
                    stk_idx[sp] <= cause_idx;
                    sp          <= sp + 1'b1;
                end
`endif
                state     <= S_TAKE;
                jump_en   <= 1'b1;
                jump_addr <= vec_addr;
                epc       <= ret_addr;
                ie        <= 1'b0;
                cause_idx <= win;
                int_ack   <= win_oh;
            end
        end
    end
endmodule

// File: tb/tb_cp0_intr_ctrl.sv
// Directed bench for cp0_intr_ctrl: register table vectors plus interrupt entry/return sequences.
module tb_cp0_intr_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  irq_in = '0;
    logic [4:0]  cp_addr_r = '0;
    logic [31:0] cp_data_r;
    logic [4:0]  cp_addr_w = '0;
    logic [31:0] cp_data_w = '0;
    logic        cp_wen = 1'b0;
    logic        eret = 1'b0;
    logic [31:0] ret_addr = '0;
    logic        take_ok = 1'b0;
    logic        jump_en;
    logic [31:0] jump_addr;
    logic [3:0]  int_ack;
    logic        in_isr;

    int tests = 0;
    int fails = 0;

    cp0_intr_ctrl #(.NUM_IRQ(4), .IRQ_EDGE(8'h01), .VEC_SHIFT(3),
                    .EBASE_RST(32'h0000_0100), .STACK_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .irq_in(irq_in),
        .cp_addr_r(cp_addr_r), .cp_data_r(cp_data_r),
        .cp_addr_w(cp_addr_w), .cp_data_w(cp_data_w), .cp_wen(cp_wen),
        .eret(eret), .ret_addr(ret_addr), .take_ok(take_ok),
        .jump_en(jump_en), .jump_addr(jump_addr), .int_ack(int_ack), .in_isr(in_isr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wen;
        logic [4:0]  aw;
        logic [31:0] dw;
        logic [4:0]  ar;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        cp_addr_r = a;
        #1;
        d = cp_data_r;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        cp_wen = 1'b1;
        cp_addr_w = a;
        cp_data_w = d;
        tick();
        cp_wen = 1'b0;
    endtask

    task automatic wait_jump(input string name, input int budget);
        int n = 0;
        while (!jump_en && n < budget) begin
            tick();
            n++;
        end
        check({name, " jump_en within budget"}, 32'(jump_en), 32'd1);
    endtask

    task automatic no_jump(input string name, input int cycles);
        logic seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (jump_en) seen = 1'b1;
        end
        check({name, " no jump_en"}, 32'(seen), 32'd0);
    endtask

    task automatic do_eret(input string name, input logic [31:0] exp_addr);
        eret = 1'b1;
        tick();
        eret = 1'b0;
        check({name, " ret jump_en"}, 32'(jump_en), 32'd1);
        check({name, " ret jump_addr"}, jump_addr, exp_addr);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;

        vecs[0] = '{1'b1, 5'd15, 32'h0000_2000, 5'd15, 32'h0000_2000};
        vecs[1] = '{1'b1, 5'd14, 32'h1234_5678, 5'd14, 32'h1234_5678};
        vecs[2] = '{1'b1, 5'd12, 32'hFFFF_FFFF, 5'd12, 32'h0000_0F01};
        vecs[3] = '{1'b1, 5'd12, 32'h0000_0000, 5'd12, 32'h0000_0000};
        vecs[4] = '{1'b1, 5'd5,  32'hFFFF_FFFF, 5'd5,  32'h0000_0000};
        vecs[5] = '{1'b1, 5'd13, 32'hFFFF_FFFF, 5'd13, 32'h0000_0000};
        vecs[6] = '{1'b0, 5'd0,  32'h0000_0000, 5'd0,  32'h0000_0000};
        vecs[7] = '{1'b1, 5'd15, 32'hFFFF_FFF0, 5'd15, 32'hFFFF_FFF0};
        vecs[8] = '{1'b1, 5'd15, 32'h0000_0100, 5'd15, 32'h0000_0100};

        #12;
        rd(5'd12, d); check("reset STATUS", d, 32'h0);
        rd(5'd13, d); check("reset CAUSE", d, 32'h0);
        rd(5'd14, d); check("reset EPC", d, 32'h0);
        rd(5'd15, d); check("reset EBASE", d, 32'h100);
        check("reset jump_en", 32'(jump_en), 32'd0);
        check("reset in_isr", 32'(in_isr), 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) begin
            cp_wen = vecs[i].wen;
            cp_addr_w = vecs[i].aw;
            cp_data_w = vecs[i].dw;
            tick();
            cp_wen = 1'b0;
            rd(vecs[i].ar, d);
            check($sformatf("regvec %0d", i), d, vecs[i].exp);
        end

        // Level channel 2, exact 3-cycle latency, mtc0 EPC in the decision cycle loses.
        wr(5'd12, 32'h0000_0F01);
        ret_addr = 32'h40;
        take_ok = 1'b1;
        irq_in = 4'b0100;
        tick();
        tick();
        cp_wen = 1'b1; cp_addr_w = 5'd14; cp_data_w = 32'hDEAD_BEEF;
        tick();
        cp_wen = 1'b0;
        check("ch2 jump_en cycle3", 32'(jump_en), 32'd1);
        check("ch2 jump_addr", jump_addr, 32'h110);
        check("ch2 int_ack", 32'(int_ack), 32'h4);
        rd(5'd14, d); check("ch2 EPC", d, 32'h40);
        rd(5'd12, d); check("ch2 STATUS IE cleared", d, 32'h0000_0F00);
        rd(5'd13, d); check("ch2 CAUSE", d, 32'h0800_0400);
        irq_in = 4'b0000;
        tick();
        check("ch2 in_isr", 32'(in_isr), 32'd1);
        check("ch2 jump_en pulse", 32'(jump_en), 32'd0);
        do_eret("ch2", 32'h40);
        rd(5'd12, d); check("ch2 STATUS IE restored", d, 32'h0000_0F01);
        check("ch2 in_isr after ret", 32'(in_isr), 32'd0);

        // Channels 1 and 3 together: priority, then 3 follows after return.
        ret_addr = 32'h80;
        irq_in = 4'b1010;
        wait_jump("ch1", 10);
        check("ch1 jump_addr", jump_addr, 32'h108);
        check("ch1 int_ack", 32'(int_ack), 32'h2);
        ret_addr = 32'h84;
        irq_in = 4'b1000;
        tick();
        do_eret("ch1", 32'h80);
        wait_jump("ch3 follow", 10);
        check("ch3 jump_addr", jump_addr, 32'h118);
        check("ch3 int_ack", 32'(int_ack), 32'h8);
        irq_in = 4'b0000;
        tick();
        do_eret("ch3", 32'h84);

        // Masked edge channel 0: pending visible, W1C clears, eret in IDLE ignored.
        wr(5'd12, 32'h0000_0E01);
        irq_in = 4'b0001;
        no_jump("masked ch0", 6);
        irq_in = 4'b0000;
        rd(5'd13, d); check("masked ch0 PEND", d, 32'h0C00_0100);
        wr(5'd13, 32'h0000_0100);
        rd(5'd13, d); check("ch0 W1C", d, 32'h0C00_0000);
        eret = 1'b1;
        tick();
        eret = 1'b0;
        check("eret idle ignored", 32'(jump_en), 32'd0);
        wr(5'd12, 32'h0000_0F01);
        no_jump("ch0 after W1C", 4);

        // take_ok held low.
        take_ok = 1'b0;
        ret_addr = 32'hC0;
        irq_in = 4'b0100;
        no_jump("take_ok low", 7);
        take_ok = 1'b1;
        tick();
        check("take_ok rise jump_en", 32'(jump_en), 32'd1);
        check("take_ok rise jump_addr", jump_addr, 32'h110);
        irq_in = 4'b0000;
        tick();
        do_eret("take_ok", 32'hC0);

        // Vector arithmetic wraps modulo 2^32.
        wr(5'd15, 32'hFFFF_FFF0);
        irq_in = 4'b1000;
        wait_jump("wrap", 10);
        check("wrap jump_addr", jump_addr, 32'h0000_0008);
        irq_in = 4'b0000;
        tick();
        do_eret("wrap", 32'hC0);
        wr(5'd15, 32'h0000_0100);

        // Channel 0 rises while in channel 3's handler.
        ret_addr = 32'h200;
        irq_in = 4'b1000;
        wait_jump("outer ch3", 10);
        check("outer ch3 jump_addr", jump_addr, 32'h118);
        ret_addr = 32'h300;
        irq_in = 4'b1001;
`ifdef CP0_NESTED_EN
        wait_jump("preempt ch0", 10);
        check("preempt jump_addr", jump_addr, 32'h100);
        check("preempt int_ack", 32'(int_ack), 32'h1);
        irq_in = 4'b1000;
        tick();
        check("preempt in_isr", 32'(in_isr), 32'd1);
        do_eret("inner", 32'h300);
        check("inner ret in_isr", 32'(in_isr), 32'd1);
        rd(5'd14, d); check("restored EPC", d, 32'h200);
        irq_in = 4'b0000;
        tick();
        tick();
        do_eret("outer", 32'h200);
        check("outer ret in_isr", 32'(in_isr), 32'd0);
`else
        no_jump("no preempt", 6);
        check("no preempt in_isr", 32'(in_isr), 32'd1);
        irq_in = 4'b0000;
        wr(5'd13, 32'h0000_0100);
        tick();
        tick();
        do_eret("outer", 32'h200);
        no_jump("after outer", 4);
`endif

        // Reset in the TAKE cycle drops the pulse immediately.
        ret_addr = 32'h500;
        irq_in = 4'b0100;
        wait_jump("pre-reset", 10);
        rst_n = 1'b0;
        #2;
        check("mid reset jump_en", 32'(jump_en), 32'd0);
        check("mid reset jump_addr", jump_addr, 32'h0);
        rd(5'd12, d); check("mid reset STATUS", d, 32'h0);
        irq_in = 4'b0000;
        tick();
        rst_n = 1'b1;
        no_jump("post reset", 4);
        check("post reset in_isr", 32'(in_isr), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
